// File: rtl/seeded_sweep_generator_pkg.sv
// Shared AES types plus the sweep-generator state encoding and helpers.
package seeded_sweep_generator_pkg;

  localparam int AES_STATE_SIZE = 128;
  typedef logic [AES_STATE_SIZE-1:0] state_t;

  typedef enum logic [2:0] {
    IDLE,
    PHASE_RST,
    PLAIN_SWEEP,
    KEY_SWEEP,
    FINAL
  } sweep_state_t;

  localparam int SWEEP_VECTORS    = 257;
  localparam int PHASE_RST_CYCLES = 2;

  // Flip a single bit of the state; bit 0 is the numeric LSB of the packed vector.
  function automatic state_t flipBit(input state_t seed, input int bitPos);
    return seed ^ (state_t'(1) << bitPos);
  endfunction

endpackage

// File: rtl/seeded_sweep_generator.sv
// Expands one plaintext/key seed into the 257-vector avalanche sweep:
// 128 plaintext bit flips, the same flips under the inverted key, then the seed itself.
module seeded_sweep_generator
  import seeded_sweep_generator_pkg::*;
#(
  parameter int KEY_SIZE  = 128,
  parameter int KEY_BYTES = KEY_SIZE / 8
) (
  input  logic                        clock,
  input  logic                        resetN,
  input  logic                        seedValid,
  output logic                        seedReady,
  input  state_t                      seedPlain,
  input  logic [0:KEY_BYTES-1][7:0]   seedKey,
  output logic                        outValid,
  input  logic                        outReady,
  output state_t                      plainData,
  output logic [0:KEY_BYTES-1][7:0]   inputKey,
  output logic [0:KEY_BYTES-1][7:0]   encryptKey,
  output logic [8:0]                  vectorIndex,
  output logic                        lastVector,
  output logic                        phaseReset
);

  typedef logic [0:KEY_BYTES-1][7:0] key_t;

  sweep_state_t state, nextState;
  logic         firstSeed, nextFirstSeed;
  logic [6:0]   bitCount, nextBitCount;
  logic [1:0]   phaseCount, nextPhaseCount;
  state_t       seedPlainReg;
  key_t         seedKeyReg;
  logic         loadSeed;
  logic         accept;

  state_t       plainSource;
  key_t         keySource;
  logic         nextSeedReady, nextOutValid, nextLastVector, nextPhaseReset;
  state_t       nextPlainData;
  key_t         nextInputKey, nextEncryptKey;
  logic [8:0]   nextVectorIndex;

  assign accept      = outValid & outReady;
  assign plainSource = loadSeed ? seedPlain : seedPlainReg;
  assign keySource   = loadSeed ? seedKey : seedKeyReg;

  // Sweep sequencing: seed capture, the one-time phase-reset window, and the bit counter.
  always_comb begin
    nextState      = state;
    nextFirstSeed  = firstSeed;
    nextBitCount   = bitCount;
    nextPhaseCount = phaseCount;
    loadSeed       = 1'b0;
    unique case (state)
      IDLE: begin
        if (seedValid) begin
          loadSeed = 1'b1;
          nextBitCount = '0;
          if (firstSeed) begin
            nextState      = PHASE_RST;
            nextFirstSeed  = 1'b0;
            nextPhaseCount = '0;
          end else begin
            nextState = PLAIN_SWEEP;
          end
        end
      end
      PHASE_RST: begin
        if (phaseCount == 2'(PHASE_RST_CYCLES - 1)) begin
          nextState    = PLAIN_SWEEP;
          nextBitCount = '0;
        end else begin
          nextPhaseCount = phaseCount + 2'd1;
        end
      end
      PLAIN_SWEEP: begin
        if (accept) begin
          nextBitCount = bitCount + 7'd1;
          if (bitCount == 7'd127) nextState = KEY_SWEEP;
        end
      end
      KEY_SWEEP: begin
        if (accept) begin
          nextBitCount = bitCount + 7'd1;
          if (bitCount == 7'd127) nextState = FINAL;
        end
      end
      FINAL: begin
        if (accept) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state so every output is a flop.
  always_comb begin
    nextSeedReady   = 1'b0;
    nextOutValid    = 1'b0;
    nextLastVector  = 1'b0;
    nextPhaseReset  = 1'b0;
    nextPlainData   = '0;
    nextInputKey    = '0;
    nextEncryptKey  = '0;
    nextVectorIndex = '0;
    unique case (nextState)
      IDLE:      nextSeedReady = 1'b1;
      PHASE_RST: nextPhaseReset = 1'b1;
      PLAIN_SWEEP: begin
        nextOutValid    = 1'b1;
        nextPlainData   = flipBit(plainSource, int'(nextBitCount));
        nextInputKey    = keySource;
        nextEncryptKey  = keySource;
        nextVectorIndex = {2'b00, nextBitCount};
      end
      KEY_SWEEP: begin
        nextOutValid    = 1'b1;
        nextPlainData   = flipBit(plainSource, int'(nextBitCount));
        nextInputKey    = ~keySource;
        nextEncryptKey  = keySource;
        nextVectorIndex = {2'b01, nextBitCount};
      end
      FINAL: begin
        nextOutValid    = 1'b1;
        nextPlainData   = plainSource;
        nextInputKey    = keySource;
        nextEncryptKey  = keySource;
        nextVectorIndex = 9'(SWEEP_VECTORS - 1);
        nextLastVector  = 1'b1;
      end
      default: nextSeedReady = 1'b1;
    endcase
  end

  // Control state, seed capture and registered outputs; reset re-arms the phase-reset pulse.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      firstSeed    <= 1'b1;
      bitCount     <= '0;
      phaseCount   <= '0;
      seedPlainReg <= '0;
      seedKeyReg   <= '0;
      seedReady    <= 1'b1;
      outValid     <= 1'b0;
      plainData    <= '0;
      inputKey     <= '0;
      encryptKey   <= '0;
      vectorIndex  <= '0;
      lastVector   <= 1'b0;
      phaseReset   <= 1'b0;
    end else begin
      state      <= nextState;
      firstSeed  <= nextFirstSeed;
      bitCount   <= nextBitCount;
      phaseCount <= nextPhaseCount;
      if (loadSeed) begin
        seedPlainReg <= seedPlain;
        seedKeyReg   <= seedKey;
      end
      seedReady   <= nextSeedReady;
      outValid    <= nextOutValid;
      plainData   <= nextPlainData;
      inputKey    <= nextInputKey;
      encryptKey  <= nextEncryptKey;
      vectorIndex <= nextVectorIndex;
      lastVector  <= nextLastVector;
      phaseReset  <= nextPhaseReset;
    end
  end

endmodule

// File: tb/tb_seeded_sweep_generator.sv
// Directed, self-checking bench for seeded_sweep_generator (128-bit and 256-bit key instances).
module tb_seeded_sweep_generator;
  import seeded_sweep_generator_pkg::*;

  typedef struct {
    int           idx;
    logic [127:0] plain;
    logic [127:0] inKey;
    logic [127:0] encKey;
    logic         last;
  } sweepVector_t;

  logic clock = 1'b0;
  logic resetN;
  logic seedValid;
  logic outReady;
  state_t seedPlain;
  logic [0:15][7:0] seedKey128;
  logic [0:31][7:0] seedKey256;

  logic seedReady, outValid, lastVector, phaseReset;
  state_t plainData;
  logic [0:15][7:0] inputKey, encryptKey;
  logic [8:0] vectorIndex;

  logic seedReady2, outValid2, lastVector2, phaseReset2;
  state_t plainData2;
  logic [0:31][7:0] inputKey2, encryptKey2;
  logic [8:0] vectorIndex2;

  int errors = 0;
  int checks = 0;

  sweepVector_t vectors[7];

  localparam logic [127:0] KEY_A   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [255:0] KEY_B   = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] PLAIN_2 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
  localparam logic [127:0] KEY_2   = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] PLAIN_X = 128'h11111111222222223333333344444444;
  localparam logic [127:0] PLAIN_3 = 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F;
  localparam logic [127:0] PLAIN_4 = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A4;

  seeded_sweep_generator #(.KEY_SIZE(128)) dut128 (
    .clock(clock), .resetN(resetN), .seedValid(seedValid), .seedReady(seedReady),
    .seedPlain(seedPlain), .seedKey(seedKey128), .outValid(outValid), .outReady(outReady),
    .plainData(plainData), .inputKey(inputKey), .encryptKey(encryptKey),
    .vectorIndex(vectorIndex), .lastVector(lastVector), .phaseReset(phaseReset)
  );

  seeded_sweep_generator #(.KEY_SIZE(256)) dut256 (
    .clock(clock), .resetN(resetN), .seedValid(seedValid), .seedReady(seedReady2),
    .seedPlain(seedPlain), .seedKey(seedKey256), .outValid(outValid2), .outReady(outReady),
    .plainData(plainData2), .inputKey(inputKey2), .encryptKey(encryptKey2),
    .vectorIndex(vectorIndex2), .lastVector(lastVector2), .phaseReset(phaseReset2)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic valid, input logic [127:0] plain,
                               input logic [127:0] key, input logic ready);
    seedValid  = valid;
    seedPlain  = plain;
    seedKey128 = key;
    seedKey256 = KEY_B;
    outReady   = ready;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] expPlain(input logic [127:0] seed, input int k);
    if (k == 256) return seed;
    return seed ^ (128'b1 << (k % 128));
  endfunction

  function automatic logic [127:0] expKey(input logic [127:0] key, input int k);
    if (k >= 128 && k < 256) return ~key;
    return key;
  endfunction

  initial begin
    logic [127:0] prevPlain;
    logic [127:0] prevKey;
    logic [8:0]   prevIndex;
    logic         prevValid;
    logic         ready;
    logic         pulsed;
    int           k;
    int           cycles;
    int           validCount;

    vectors[0] = '{0,   128'h1,                                KEY_A,  KEY_A, 1'b0};
    vectors[1] = '{1,   128'h2,                                KEY_A,  KEY_A, 1'b0};
    vectors[2] = '{127, 128'h80000000000000000000000000000000, KEY_A,  KEY_A, 1'b0};
    vectors[3] = '{128, 128'h1, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, KEY_A, 1'b0};
    vectors[4] = '{129, 128'h2, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, KEY_A, 1'b0};
    vectors[5] = '{255, 128'h80000000000000000000000000000000,
                   128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, KEY_A, 1'b0};
    vectors[6] = '{256, 128'h0,                                KEY_A,  KEY_A, 1'b1};

    // Reset state
    resetN = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b1);
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    checkOutput("reset seedReady", 256'(seedReady), 256'(1));
    checkOutput("reset outValid", 256'(outValid), 256'(0));
    checkOutput("reset plainData", 256'(plainData), 256'(0));
    checkOutput("reset inputKey", 256'(inputKey), 256'(0));
    checkOutput("reset encryptKey", 256'(encryptKey), 256'(0));
    checkOutput("reset vectorIndex", 256'(vectorIndex), 256'(0));
    checkOutput("reset lastVector", 256'(lastVector), 256'(0));
    checkOutput("reset phaseReset", 256'(phaseReset), 256'(0));
    checkOutput("reset256 flags", 256'({seedReady2, outValid2, lastVector2, phaseReset2}), 256'(4'b1000));
    checkOutput("reset256 data", 256'(plainData2) | 256'(vectorIndex2), 256'(0));
    checkOutput("reset256 keys", 256'(inputKey2) | 256'(encryptKey2), 256'(0));

    // First seed: two phase-reset cycles, then the full sweep with outReady held high
    applyStimulus(1'b1, 128'h0, KEY_A, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 128'h0, KEY_A, 1'b1);
    checkOutput("phase1 phaseReset", 256'(phaseReset), 256'(1));
    checkOutput("phase1 outValid", 256'(outValid), 256'(0));
    checkOutput("phase1 seedReady", 256'(seedReady), 256'(0));
    waitCycle();
    checkOutput("phase2 phaseReset", 256'(phaseReset), 256'(1));
    checkOutput("phase2 outValid", 256'(outValid), 256'(0));
    waitCycle();
    checkOutput("post-phase phaseReset", 256'(phaseReset), 256'(0));
    validCount = 0;
    for (int v = 0; v < 257; v++) begin
      if (outValid) validCount++;
      checkOutput("sweep1 vectorIndex", 256'(vectorIndex), 256'(v));
      for (int t = 0; t < 7; t++) begin
        if (vectors[t].idx == v) begin
          checkOutput("sweep1 table plain", 256'(plainData), 256'(vectors[t].plain));
          checkOutput("sweep1 table inputKey", 256'(inputKey), 256'(vectors[t].inKey));
          checkOutput("sweep1 table encryptKey", 256'(encryptKey), 256'(vectors[t].encKey));
          checkOutput("sweep1 table lastVector", 256'(lastVector), 256'(vectors[t].last));
        end
      end
      if (v == 127) checkOutput("k256 plain flips stay 128", 256'(plainData2), 256'(vectors[2].plain));
      if (v == 128) begin
        checkOutput("k256 inputKey inverted", 256'(inputKey2), ~KEY_B);
        checkOutput("k256 encryptKey", 256'(encryptKey2), KEY_B);
      end
      if (v == 0) checkOutput("k256 inputKey plain sweep", 256'(inputKey2), KEY_B);
      if (v < 256) waitCycle();
    end
    checkOutput("sweep1 valid count", 256'(validCount), 256'(257));
    waitCycle();
    checkOutput("sweep1 end outValid", 256'(outValid), 256'(0));
    checkOutput("sweep1 end seedReady", 256'(seedReady), 256'(1));

    // Second seed accepted immediately; random stalls and a mid-sweep seed that must be ignored
    applyStimulus(1'b1, PLAIN_2, KEY_2, 1'b1);
    waitCycle();
    applyStimulus(1'b0, PLAIN_2, KEY_2, 1'b1);
    checkOutput("sweep2 no phaseReset", 256'(phaseReset), 256'(0));
    checkOutput("sweep2 first outValid", 256'(outValid), 256'(1));
    checkOutput("sweep2 first plain", 256'(plainData), 256'(PLAIN_2 ^ 128'h1));
    k = 0;
    cycles = 0;
    pulsed = 1'b0;
    while (k < 257 && cycles < 3000) begin
      checkOutput("sweep2 outValid", 256'(outValid), 256'(1));
      checkOutput("sweep2 vectorIndex", 256'(vectorIndex), 256'(k));
      checkOutput("sweep2 plain", 256'(plainData), 256'(expPlain(PLAIN_2, k)));
      checkOutput("sweep2 inputKey", 256'(inputKey), 256'(expKey(KEY_2, k)));
      checkOutput("sweep2 lastVector", 256'(lastVector), 256'(k == 256));
      ready = 1'($urandom_range(0, 1));
      if (k == 50 && !pulsed) begin
        applyStimulus(1'b1, PLAIN_X, ~KEY_2, ready);
        pulsed = 1'b1;
      end else begin
        applyStimulus(1'b0, PLAIN_2, KEY_2, ready);
      end
      prevPlain = plainData;
      prevKey   = inputKey;
      prevIndex = vectorIndex;
      prevValid = outValid;
      waitCycle();
      cycles++;
      if (prevValid && ready) begin
        k++;
      end else begin
        checkOutput("stall plain stable", 256'(plainData), 256'(prevPlain));
        checkOutput("stall key stable", 256'(inputKey), 256'(prevKey));
        checkOutput("stall index stable", 256'(vectorIndex), 256'(prevIndex));
      end
    end
    applyStimulus(1'b0, PLAIN_2, KEY_2, 1'b1);
    checkOutput("sweep2 accepts", 256'(k), 256'(257));
    checkOutput("sweep2 end outValid", 256'(outValid), 256'(0));
    checkOutput("sweep2 end seedReady", 256'(seedReady), 256'(1));

    // Third seed aborted by reset at vector 140; next seed replays the phase reset
    applyStimulus(1'b1, PLAIN_3, KEY_A, 1'b1);
    waitCycle();
    applyStimulus(1'b0, PLAIN_3, KEY_A, 1'b1);
    for (int c = 0; c < 300 && vectorIndex != 9'd140; c++) waitCycle();
    checkOutput("sweep3 reached 140", 256'(vectorIndex), 256'(140));
    checkOutput("sweep3 plain at 140", 256'(plainData), 256'(expPlain(PLAIN_3, 140)));
    #2 resetN = 1'b0;
    #1;
    checkOutput("abort outValid", 256'(outValid), 256'(0));
    checkOutput("abort seedReady", 256'(seedReady), 256'(1));
    checkOutput("abort plainData", 256'(plainData), 256'(0));
    checkOutput("abort keys", 256'(inputKey) | 256'(encryptKey), 256'(0));
    checkOutput("abort vectorIndex", 256'(vectorIndex), 256'(0));
    @(posedge clock);
    #1 resetN = 1'b1;
    waitCycle();
    applyStimulus(1'b1, PLAIN_4, KEY_2, 1'b1);
    waitCycle();
    applyStimulus(1'b0, PLAIN_4, KEY_2, 1'b1);
    checkOutput("rearm phaseReset 1", 256'(phaseReset), 256'(1));
    waitCycle();
    checkOutput("rearm phaseReset 2", 256'(phaseReset), 256'(1));
    checkOutput("rearm outValid low", 256'(outValid), 256'(0));
    waitCycle();
    checkOutput("rearm outValid", 256'(outValid), 256'(1));
    checkOutput("rearm vectorIndex", 256'(vectorIndex), 256'(0));
    checkOutput("rearm plain", 256'(plainData), 256'(PLAIN_4 ^ 128'h1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
